inst_queue: RTL and testbench

Circular instruction FIFO between the instruction fetcher and the decoder, the stage directly upstream of the reservation station. It buffers fetched (instruction, pc) pairs and issues at most one per cycle to the decoder through a registered output. Issue stalls whenever the reservation station, ROB or LSB reports full. Branch-misprediction roll-back flushes the whole queue.

---
 rtl/inst_queue.sv | 96 +++++++++
 tb/tb_inst_queue.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_queue.sv
// Circular instruction FIFO between the fetcher and the decoder, with a registered issue port.
// Optional IQ_BYPASS_EN: an instruction that arrives at an empty queue issues directly (1-cycle latency).
module inst_queue #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        IF_input_valid,
    input  logic [31:0] IF_inst,
    input  logic [31:0] IF_inst_pc,
    output logic        IF_IQ_is_full,
    input  logic        RS_is_full,
    input  logic        ROB_is_full,
    input  logic        LSB_is_full,
    output logic        ID_output_valid,
    output logic [31:0] ID_inst,
    output logic [31:0] ID_inst_pc,
    input  logic        ROB_roll_back_flag
);

    localparam logic [ADDR_W:0] CNT_DEPTH = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_FULL  = (ADDR_W + 1)'(DEPTH - 1);

    logic [31:0]       inst_mem [DEPTH];
    logic [31:0]       pc_mem   [DEPTH];
    logic [ADDR_W-1:0] head;
    logic [ADDR_W-1:0] tail;
    logic [ADDR_W:0]   count;

    logic stall;
    logic push;
    logic pop;
    logic bypass;
    logic store;

    // A bypassed instruction goes straight to the output and never occupies a slot.
    always_comb begin
        stall  = RS_is_full | ROB_is_full | LSB_is_full;
        push   = IF_input_valid && (count < CNT_DEPTH);
        pop    = (count != '0) && !stall;
        bypass = 1'b0;
`ifdef IQ_BYPASS_EN
        bypass = IF_input_valid && (count == '0) && !stall;
`endif
        store  = push && !bypass;
    end

    // One slot of slack absorbs a fetch already in flight when full rises.
    assign IF_IQ_is_full = (count >= CNT_FULL);

    always_ff @(posedge clk) begin
        if (rst && rdy && !ROB_roll_back_flag && store) begin
            inst_mem[tail] <= IF_inst;
            pc_mem[tail]   <= IF_inst_pc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head            <= '0;
            tail            <= '0;
            count           <= '0;
            ID_output_valid <= 1'b0;
            ID_inst         <= '0;
            ID_inst_pc      <= '0;
        end else if (ROB_roll_back_flag) begin
            head            <= '0;
            tail            <= '0;
            count           <= '0;
            ID_output_valid <= 1'b0;
        end else if (!rdy) begin
            ID_output_valid <= 1'b0;
        end else begin
            ID_output_valid <= pop || bypass;
            if (bypass) begin
                ID_inst    <= IF_inst;
                ID_inst_pc <= IF_inst_pc;
            end else if (pop) begin
                ID_inst    <= inst_mem[head];
                ID_inst_pc <= pc_mem[head];
                head       <= head + 1'b1;
            end
            if (store) begin
                tail <= tail + 1'b1;
            end
            if (store && !pop) begin
                count <= count + 1'b1;
            end else if (!store && pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// Bench for inst_queue: queue-level model compared every cycle plus directed literal checks.
// Honours IQ_BYPASS_EN so the same bench covers both builds.
module tb_inst_queue;

`ifdef IQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdy = 1'b1;
    logic        IF_input_valid = 1'b0;
    logic [31:0] IF_inst = '0;
    logic [31:0] IF_inst_pc = '0;
    logic        IF_IQ_is_full;
    logic        RS_is_full = 1'b0;
    logic        ROB_is_full = 1'b0;
    logic        LSB_is_full = 1'b0;
    logic        ID_output_valid;
    logic [31:0] ID_inst;
    logic [31:0] ID_inst_pc;
    logic        ROB_roll_back_flag = 1'b0;

    inst_queue #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk(clk),
        .rst(rst_n),
        .rdy(rdy),
        .IF_input_valid(IF_input_valid),
        .IF_inst(IF_inst),
        .IF_inst_pc(IF_inst_pc),
        .IF_IQ_is_full(IF_IQ_is_full),
        .RS_is_full(RS_is_full),
        .ROB_is_full(ROB_is_full),
        .LSB_is_full(LSB_is_full),
        .ID_output_valid(ID_output_valid),
        .ID_inst(ID_inst),
        .ID_inst_pc(ID_inst_pc),
        .ROB_roll_back_flag(ROB_roll_back_flag)
    );

    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;
    int pulse_cnt = 0;
    bit cmp_en = 1'b0;
    logic [31:0] issued [$];

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual === expected) passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Model: a plain queue of pending instructions and the last issued pair.
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } item_t;

    item_t       mq [$];
    item_t       m_item;
    logic        m_valid = 1'b0;
    logic [31:0] m_inst = '0;
    logic [31:0] m_pc = '0;
    int          m_pre;
    bit          m_stall;

    always @(negedge rst_n) begin
        mq.delete();
        m_valid = 1'b0;
        m_inst  = '0;
        m_pc    = '0;
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (ROB_roll_back_flag) begin
                mq.delete();
                m_valid = 1'b0;
            end else if (!rdy) begin
                m_valid = 1'b0;
            end else begin
                m_stall = RS_is_full || ROB_is_full || LSB_is_full;
                m_pre   = mq.size();
                m_valid = 1'b0;
                if (BYP && m_pre == 0 && IF_input_valid && !m_stall) begin
                    m_valid = 1'b1;
                    m_inst  = IF_inst;
                    m_pc    = IF_inst_pc;
                end else begin
                    if (m_pre > 0 && !m_stall) begin
                        m_item  = mq.pop_front();
                        m_valid = 1'b1;
                        m_inst  = m_item.inst;
                        m_pc    = m_item.pc;
                    end
                    if (IF_input_valid && m_pre < 16)
                        mq.push_back(item_t'{inst: IF_inst, pc: IF_inst_pc});
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            check_output("valid", ID_output_valid, m_valid);
            check_output("inst", ID_inst, m_inst);
            check_output("pc", ID_inst_pc, m_pc);
            check_output("full", IF_IQ_is_full, mq.size() >= 15);
            if (ID_output_valid) begin
                pulse_cnt++;
                issued.push_back(ID_inst_pc);
            end
        end
    end

    task automatic apply_stimulus(input bit v, input logic [31:0] inst, input logic [31:0] pc,
                                  input bit rs, input bit rob, input bit rb, input bit r);
        @(negedge clk);
        IF_input_valid     = v;
        IF_inst            = inst;
        IF_inst_pc         = pc;
        RS_is_full         = rs;
        ROB_is_full        = rob;
        LSB_is_full        = 1'b0;
        ROB_roll_back_flag = rb;
        rdy                = r;
        #1;
    endtask

    task automatic push_pc(input logic [31:0] pc, input bit rs);
        apply_stimulus(1'b1, {pc[19:0], 12'h013}, pc, rs, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic idle(input int n, input bit rs);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, '0, '0, rs, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int bad;
        #12;
        check_output("reset_valid", ID_output_valid, 1'b0);
        check_output("reset_pc", ID_inst_pc, 32'h0);
        check_output("reset_full", IF_IQ_is_full, 1'b0);
        @(negedge clk);
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        // Three back-to-back pushes with no stall
        apply_stimulus(1'b1, 32'h13, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        apply_stimulus(1'b1, 32'h13, 32'h4, 1'b0, 1'b0, 1'b0, 1'b1);
        check_output("t1_latency", ID_output_valid, BYP ? 1'b1 : 1'b0);
        apply_stimulus(1'b1, 32'h13, 32'h8, 1'b0, 1'b0, 1'b0, 1'b1);
        check_output("t1_pulse1_valid", ID_output_valid, 1'b1);
        check_output("t1_pulse1_pc", ID_inst_pc, BYP ? 32'h4 : 32'h0);
        idle(1, 1'b0);
        check_output("t1_pulse2_pc", ID_inst_pc, BYP ? 32'h8 : 32'h4);
        idle(1, 1'b0);
        check_output("t1_pulse3_valid", ID_output_valid, BYP ? 1'b0 : 1'b1);
        check_output("t1_pulse3_pc", ID_inst_pc, 32'h8);
        idle(2, 1'b0);
        check_output("t1_done", ID_output_valid, 1'b0);

        // Fill under RS stall: full flag, 16th accepted, 17th dropped
        issued.delete();
        for (int i = 0; i < 15; i++) push_pc(32'h1000 + 4 * i, 1'b1);
        push_pc(32'h103C, 1'b1);
        check_output("t2_full15", IF_IQ_is_full, 1'b1);
        check_output("t2_count15", dut.count, 15);
        push_pc(32'h1040, 1'b1);
        check_output("t2_count16", dut.count, 16);
        idle(1, 1'b1);
        check_output("t2_drop17", dut.count, 16);
        pulse_cnt = 0;
        idle(20, 1'b0);
        check_output("t2_pulses", pulse_cnt, 16);
        check_output("t2_last_pc", issued[issued.size() - 1], 32'h103C);
        check_output("t2_idle", ID_output_valid, 1'b0);

        // Streaming with occasional ROB stall across pointer wrap
        issued.delete();
        for (int i = 0; i < 40; i++)
            apply_stimulus(1'b1, 32'h13, 4 * i, 1'b0, $urandom_range(0, 3) == 0, 1'b0, 1'b1);
        idle(45, 1'b0);
        check_output("t3_count", issued.size(), 40);
        bad = 0;
        for (int i = 0; i < issued.size() && i < 40; i++)
            if (issued[i] !== 32'(4 * i)) bad++;
        check_output("t3_order", bad, 0);

        // Roll-back with a simultaneous push
        issued.delete();
        for (int i = 0; i < 5; i++) push_pc(32'h3000 + 4 * i, 1'b1);
        apply_stimulus(1'b1, 32'h13, 32'h100, 1'b1, 1'b0, 1'b1, 1'b1);
        idle(1, 1'b0);
        check_output("t4_count0", dut.count, 0);
        check_output("t4_valid0", ID_output_valid, 1'b0);
        idle(3, 1'b0);
        push_pc(32'h200, 1'b0);
        idle(4, 1'b0);
        check_output("t4_issued_n", issued.size(), 1);
        check_output("t4_issued_pc", issued[0], 32'h200);

        // rdy low freezes the queue
        for (int i = 0; i < 3; i++) push_pc(32'h4000 + 4 * i, 1'b1);
        pulse_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
            check_output("t5_count_hold", dut.count, 3);
        end
        idle(1, 1'b0);
        check_output("t5_no_pulse", pulse_cnt, 0);
        idle(4, 1'b0);
        check_output("t5_pulses", pulse_cnt, 3);

        // Asynchronous reset between edges
        for (int i = 0; i < 8; i++) push_pc(32'h5000 + 4 * i, 1'b1);
        idle(1, 1'b0);
        @(posedge clk);
        #2;
        check_output("t6_pre_count", dut.count, 7);
        check_output("t6_pre_valid", ID_output_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check_output("t6_valid", ID_output_valid, 1'b0);
        check_output("t6_full", IF_IQ_is_full, 1'b0);
        check_output("t6_count", dut.count, 0);
        check_output("t6_pc", ID_inst_pc, 32'h0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        push_pc(32'h6000, 1'b0);
        idle(4, 1'b0);
        check_output("t6_recover_pc", ID_inst_pc, 32'h6000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
